umstr_pkt_buf_reader: RTL and testbench

Read-side engine of the UDPMaster frame buffer. It accepts frame descriptors (start address and length), fetches the frame words from the read port of the dual-port frame RAM, and streams them out as an AXI-Stream-style master with `m_tlast` on the final word. When the frame has fully left the block, it issues a release pulse so the write side can reclaim the RAM space. It sits between the frame RAM's read port and the downstream MAC/TX stream.

---
 rtl/umstr_pkt_buf_reader.sv | 195 +++++++++++++++++++
 tb/tb_umstr_pkt_buf_reader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/umstr_pkt_buf_reader.sv
// umstr_pkt_buf_reader
// Read-side engine of the UDPMaster frame buffer. Takes one frame
// descriptor at a time and fetches that frame's words from the frame RAM
// read port. It streams them out with m_tlast on the final word. Once the
// last word has been handshaken it pulses a release so the write side can
// reclaim the space.
//
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   desc_addr/len/valid   frame descriptor in (len in words, 0..2^ADDR_WIDTH)
//   desc_ready            descriptor accept (high only while idle)
//   ram_addr              registered RAM read address
//   ram_q                 RAM read data, valid one cycle after ram_addr sampled
//   m_tdata/tvalid/tlast  stream master out
//   m_tready              downstream ready
//   rel_valid, rel_len    one-cycle release pulse with the frame length
module umstr_pkt_buf_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6,
   parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] desc_addr,
   input  logic [LEN_WIDTH-1:0]  desc_len,
   input  logic                  desc_valid,
   output logic                  desc_ready,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [DATA_WIDTH-1:0] ram_q,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   output logic                  m_tlast,
   input  logic                  m_tready,
   output logic                  rel_valid,
   output logic [LEN_WIDTH-1:0]  rel_len
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [LEN_WIDTH-1:0]  LEN_ZERO = {LEN_WIDTH{1'b0}};
   localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]            state_r;
   logic [1:0]            state_next_s;
   logic                  desc_ready_r;
   logic [ADDR_WIDTH-1:0] ram_addr_r;
   logic [LEN_WIDTH-1:0]  remaining_r;
   logic [LEN_WIDTH-1:0]  len_r;
   logic                  inflight_r;
   logic                  inflight_last_r;
   logic                  rel_valid_r;
   logic [LEN_WIDTH-1:0]  rel_len_r;

   logic                  head_valid_r;
   logic [DATA_WIDTH-1:0] head_data_r;
   logic                  head_last_r;
   logic                  second_valid_r;
   logic [DATA_WIDTH-1:0] second_data_r;
   logic                  second_last_r;

   logic                  accept_s;
   logic                  pop_s;
   logic [2:0]            occ_s;
   logic                  issue_s;
   logic                  final_s;
   logic                  done_s;

   assign accept_s = (state_r == ST_IDLE) & desc_valid & desc_ready_r;
   assign pop_s    = head_valid_r & m_tready;
   // Words buffered plus the read whose data is still on its way from RAM.
   assign occ_s    = {2'b00, head_valid_r} + {2'b00, second_valid_r} + {2'b00, inflight_r};
   // A pop this cycle frees one slot, so the credit limit grows by the pop.
   assign issue_s  = (state_r == ST_READ) && (remaining_r != LEN_ZERO) &&
                     (occ_s < (3'd2 + {2'b00, pop_s}));
   assign final_s  = issue_s && (remaining_r == LEN_ONE);
   assign done_s   = (state_r == ST_DRAIN) && pop_s && head_last_r;

   // Next-state logic of the frame FSM.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && (desc_len != LEN_ZERO)) begin
               state_next_s = ST_READ;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_READ: begin
            if (final_s) begin
               state_next_s = ST_DRAIN;
            end else begin
               state_next_s = ST_READ;
            end
         end
         ST_DRAIN: begin
            if (done_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_DRAIN;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Frame control: FSM state, read address/counter, in-flight tag, release pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r         <= ST_IDLE;
         desc_ready_r    <= 1'b0;
         ram_addr_r      <= {ADDR_WIDTH{1'b0}};
         remaining_r     <= LEN_ZERO;
         len_r           <= LEN_ZERO;
         inflight_r      <= 1'b0;
         inflight_last_r <= 1'b0;
         rel_valid_r     <= 1'b0;
         rel_len_r       <= LEN_ZERO;
      end else begin
         state_r         <= state_next_s;
         // Registered so it stays low during reset and rises one edge after.
         desc_ready_r    <= (state_next_s == ST_IDLE);
         inflight_r      <= issue_s;
         inflight_last_r <= final_s;
         rel_valid_r     <= done_s;
         if (done_s) begin
            rel_len_r <= len_r;
         end
         if (accept_s) begin
            ram_addr_r  <= desc_addr;
            remaining_r <= desc_len;
            len_r       <= desc_len;
         end else if (issue_s) begin
            // Natural wrap at 2^ADDR_WIDTH.
            ram_addr_r  <= ram_addr_r + ADDR_ONE;
            remaining_r <= remaining_r - LEN_ONE;
         end
      end
   end

   // Two-entry output buffer: head drives the stream, second absorbs the
   // word still arriving from RAM when the head stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_valid_r   <= 1'b0;
         head_data_r    <= {DATA_WIDTH{1'b0}};
         head_last_r    <= 1'b0;
         second_valid_r <= 1'b0;
         second_data_r  <= {DATA_WIDTH{1'b0}};
         second_last_r  <= 1'b0;
      end else if (pop_s) begin
         if (second_valid_r) begin
            head_valid_r <= 1'b1;
            head_data_r  <= second_data_r;
            head_last_r  <= second_last_r;
            if (inflight_r) begin
               second_data_r  <= ram_q;
               second_last_r  <= inflight_last_r;
               second_valid_r <= 1'b1;
            end else begin
               second_valid_r <= 1'b0;
            end
         end else if (inflight_r) begin
            head_valid_r <= 1'b1;
            head_data_r  <= ram_q;
            head_last_r  <= inflight_last_r;
         end else begin
            head_valid_r <= 1'b0;
            head_last_r  <= 1'b0;
         end
      end else if (inflight_r) begin
         if (!head_valid_r) begin
            head_valid_r <= 1'b1;
            head_data_r  <= ram_q;
            head_last_r  <= inflight_last_r;
         end else begin
            second_valid_r <= 1'b1;
            second_data_r  <= ram_q;
            second_last_r  <= inflight_last_r;
         end
      end
   end

   assign desc_ready = desc_ready_r;
   assign ram_addr   = ram_addr_r;
   assign m_tvalid   = head_valid_r;
   assign m_tdata    = head_data_r;
   assign m_tlast    = head_last_r;
   assign rel_valid  = rel_valid_r;
   assign rel_len    = rel_len_r;

endmodule

// File: tb/tb_umstr_pkt_buf_reader.sv
// Bench for umstr_pkt_buf_reader: directed frames plus random frames,
// checked every cycle against a queue-based model of the expected beats.
module tb_umstr_pkt_buf_reader;
   localparam int AW = 6;
   localparam int DW = 8;
   localparam int LW = 7;
   localparam int DEPTH = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [AW-1:0] desc_addr = '0;
   logic [LW-1:0] desc_len = '0;
   logic          desc_valid = 1'b0;
   logic          desc_ready;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_q = '0;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tlast;
   logic          m_tready = 1'b0;
   logic          rel_valid;
   logic [LW-1:0] rel_len;

   umstr_pkt_buf_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .reset(reset),
      .desc_addr(desc_addr), .desc_len(desc_len), .desc_valid(desc_valid), .desc_ready(desc_ready),
      .ram_addr(ram_addr), .ram_q(ram_q),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
      .rel_valid(rel_valid), .rel_len(rel_len)
   );

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
      int            c;   // required handshake cycle, -1 when not timed
   } beat_t;

   logic [DW-1:0] mem [DEPTH];
   int            n_checks = 0;
   int            n_pass = 0;
   int            cyc = 0;
   bit            fast_mode = 1'b1;
   beat_t         exp_q[$];
   beat_t         e_m;
   bit            busy_m = 1'b1;
   bit            fresh_m = 1'b1;
   int            rel_due_cyc = -1;
   logic [LW-1:0] cur_len = '0;
   int            acc_cyc = 0;
   int            rel_cyc = -10;
   int            frame_beats = 0;
   logic [LW-1:0] last_rel_len = '0;
   logic [DW-1:0] cap_d[$];
   logic          cap_l[$];
   int            cap_c[$];
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_d = '0;
   logic          prev_l = 1'b0;

   always #5 clk = ~clk;

   // RAM read port with one cycle of latency.
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      ram_q <= mem[ram_addr];
   end

   // Downstream ready: always high in timed mode, coin flip otherwise.
   always @(posedge clk) begin
      #1;
      if (fast_mode) m_tready = 1'b1;
      else m_tready = ($urandom_range(0, 1) == 1);
   end

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic load_mem(input logic [7:0] key);
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i + 12) ^ key;
   endtask

   task automatic clear_cap();
      cap_d.delete(); cap_l.delete(); cap_c.delete();
   endtask

   // Reference model and per-cycle compare.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         busy_m = 1'b1; fresh_m = 1'b1; rel_due_cyc = -1; prev_stall = 1'b0;
      end else begin
         chk(desc_ready == !busy_m, "desc_ready", desc_ready, !busy_m);
         if (fresh_m) begin busy_m = 1'b0; fresh_m = 1'b0; end
         if (prev_stall)
            chk(m_tvalid && m_tdata == prev_d && m_tlast == prev_l, "hold_while_stalled",
                {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_l, prev_d});
         if (m_tvalid && exp_q.size() == 0)
            chk(1'b0, "spurious_valid", {m_tlast, m_tdata}, 0);
         if (m_tvalid && m_tready && exp_q.size() > 0) begin
            e_m = exp_q.pop_front();
            chk(m_tdata == e_m.d && m_tlast == e_m.l, "beat", {m_tlast, m_tdata}, {e_m.l, e_m.d});
            if (e_m.c >= 0) chk(cyc == e_m.c, "beat_cycle", cyc, e_m.c);
            cap_d.push_back(m_tdata); cap_l.push_back(m_tlast); cap_c.push_back(cyc);
            frame_beats++;
            if (e_m.l) begin rel_due_cyc = cyc + 1; busy_m = 1'b0; end
         end
         if (cyc == rel_due_cyc) begin
            chk(rel_valid && rel_len == cur_len, "release", {rel_valid, rel_len}, {1'b1, cur_len});
            rel_cyc = cyc; last_rel_len = rel_len;
         end else if (rel_valid) begin
            chk(1'b0, "spurious_release", rel_len, 0);
         end
         if (desc_valid && desc_ready) begin
            acc_cyc = cyc;
            if (desc_len != 0) begin
               busy_m = 1'b1; cur_len = desc_len; frame_beats = 0;
               for (int i = 0; i < int'(desc_len); i++) begin
                  logic [AW-1:0] a;
                  a = desc_addr + AW'(i);
                  e_m.d = mem[a];
                  e_m.l = (i == int'(desc_len) - 1);
                  e_m.c = fast_mode ? cyc + 3 + i : -1;
                  exp_q.push_back(e_m);
               end
            end
         end
         prev_stall = m_tvalid && !m_tready;
         prev_d = m_tdata; prev_l = m_tlast;
      end
   end

   // Present a descriptor and hold it until accepted; returns at posedge+1.
   task automatic send_desc(input logic [AW-1:0] a, input logic [LW-1:0] l);
      desc_addr = a; desc_len = l; desc_valid = 1'b1;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (desc_ready) begin
            @(posedge clk); #1;
            desc_valid = 1'b0;
            return;
         end
      end
      chk(1'b0, "desc_accept_timeout", 0, 1);
      desc_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk); #1;
         if (!busy_m && exp_q.size() == 0 && cyc > rel_due_cyc) begin
            @(posedge clk); #1;
            return;
         end
      end
      chk(1'b0, "frame_done_timeout", exp_q.size(), 0);
   endtask

   task automatic check_reset_vals();
      chk(desc_ready == 1'b0, "rst_desc_ready", desc_ready, 0);
      chk(ram_addr == '0, "rst_ram_addr", ram_addr, 0);
      chk(m_tvalid == 1'b0 && m_tlast == 1'b0, "rst_tvalid_tlast", {m_tvalid, m_tlast}, 0);
      chk(m_tdata == '0, "rst_tdata", m_tdata, 0);
      chk(rel_valid == 1'b0 && rel_len == '0, "rst_release", {rel_valid, rel_len}, 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check_reset_vals();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk(desc_ready == 1'b0, "ready_low_before_edge", desc_ready, 0);
      @(posedge clk); #1;
      chk(desc_ready == 1'b1, "ready_after_reset", desc_ready, 1);
   endtask

   initial begin
      load_mem(8'h00);
      #1 reset = 1'b1;
      #2 check_reset_vals();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      chk(desc_ready == 1'b1, "ready_after_reset", desc_ready, 1);

      // Basic frame with hand-computed expectations.
      fast_mode = 1'b1; clear_cap();
      send_desc(6'd4, 7'd5);
      wait_idle();
      chk(cap_d.size() == 5, "basic_count", cap_d.size(), 5);
      for (int i = 0; i < 5 && i < cap_d.size(); i++) begin
         chk(cap_d[i] == 8'(8'h10 + i), "basic_data", cap_d[i], 8'(8'h10 + i));
         chk(cap_l[i] == (i == 4), "basic_last", cap_l[i], (i == 4));
      end
      if (cap_c.size() > 0) chk(cap_c[0] - acc_cyc == 3, "basic_latency", cap_c[0] - acc_cyc, 3);
      chk(last_rel_len == 7'd5, "basic_rel_len", last_rel_len, 5);

      // Wrap-around.
      clear_cap();
      send_desc(6'd62, 7'd4);
      wait_idle();
      chk(cap_d.size() == 4, "wrap_count", cap_d.size(), 4);
      if (cap_d.size() == 4) begin
         chk(cap_d[0] == 8'h4A && cap_d[1] == 8'h4B, "wrap_top", {cap_d[0], cap_d[1]}, 16'h4A4B);
         chk(cap_d[2] == 8'h0C && cap_d[3] == 8'h0D, "wrap_bottom", {cap_d[2], cap_d[3]}, 16'h0C0D);
      end

      // Backpressure.
      fast_mode = 1'b0; clear_cap();
      send_desc(6'd10, 7'd8);
      wait_idle();
      chk(cap_d.size() == 8, "bp_count", cap_d.size(), 8);
      for (int i = 0; i < 8 && i < cap_d.size(); i++)
         chk(cap_d[i] == 8'(22 + i), "bp_data", cap_d[i], 8'(22 + i));
      fast_mode = 1'b1;

      // Zero-length descriptor is dropped.
      clear_cap();
      send_desc(6'd5, 7'd0);
      repeat (10) @(posedge clk);
      #1;
      chk(cap_d.size() == 0, "len0_no_beats", cap_d.size(), 0);
      chk(desc_ready == 1'b1, "len0_ready", desc_ready, 1);

      // Single-word frame.
      clear_cap();
      send_desc(6'd20, 7'd1);
      wait_idle();
      chk(cap_d.size() == 1, "len1_count", cap_d.size(), 1);
      if (cap_d.size() == 1) chk(cap_d[0] == 8'h20 && cap_l[0], "len1_beat", {cap_l[0], cap_d[0]}, 9'h120);
      chk(last_rel_len == 7'd1, "len1_rel_len", last_rel_len, 1);

      // Full-buffer frame.
      clear_cap();
      send_desc(6'd7, 7'd64);
      wait_idle();
      chk(cap_d.size() == 64, "len64_count", cap_d.size(), 64);
      chk(last_rel_len == 7'd64, "len64_rel_len", last_rel_len, 64);

      // Back-to-back: second descriptor accepted in the release cycle.
      clear_cap();
      send_desc(6'd0, 7'd3);
      send_desc(6'd30, 7'd4);
      chk(acc_cyc == rel_cyc, "b2b_accept_in_release", acc_cyc, rel_cyc);
      wait_idle();
      chk(cap_d.size() == 7, "b2b_count", cap_d.size(), 7);

      // Reset in the middle of a frame.
      clear_cap();
      send_desc(6'd40, 7'd6);
      for (int k = 0; k < 100 && frame_beats < 3; k++) begin @(negedge clk); #1; end
      chk(frame_beats == 3, "midrst_three_beats", frame_beats, 3);
      do_reset();
      repeat (5) @(posedge clk);
      #1;
      chk(cap_d.size() == 3, "midrst_abandoned", cap_d.size(), 3);
      clear_cap();
      send_desc(6'd40, 7'd6);
      wait_idle();
      chk(cap_d.size() == 6, "midrst_restart", cap_d.size(), 6);

      // Random frames, random RAM contents and random backpressure.
      for (int f = 0; f < 14; f++) begin
         load_mem(8'($urandom));
         fast_mode = ($urandom_range(0, 1) == 1);
         send_desc(AW'($urandom_range(0, 63)), LW'($urandom_range(0, 64)));
         wait_idle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
